// File: rtl/edge_pe_bank_arbiter.sv
// Edge PE to memory-bank arbiter. Each free bank grants one PE per cycle,
// round-robin per bank, then holds itself busy for BANK_LAT cycles.
module edge_pe_bank_arbiter #(
    parameter int unsigned NUM_PE   = 4,
    parameter int unsigned NUM_BANK = 4,
    parameter int unsigned BANK_LAT = 3,
    parameter int unsigned BANK_W   = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PE-1:0]          req,
    input  logic [NUM_PE*BANK_W-1:0]   req_bank,
    input  logic                       conflict_clr,
    output logic [NUM_PE-1:0]          grant,
    output logic [NUM_PE*BANK_W-1:0]   grant_bank,
    output logic [NUM_BANK-1:0]        bank_busy,
    output logic [15:0]                conflict_cnt,
    output logic                       bank_err
);

    localparam int unsigned PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [3:0]  LAT  = 4'(BANK_LAT);

    logic [NUM_PE-1:0]        r_grant;
    logic [NUM_PE*BANK_W-1:0] r_grant_bank;
    logic [NUM_BANK-1:0]      r_busy;
    logic [15:0]              r_conflict;
    logic                     r_err;
    logic [3:0]               r_cnt [NUM_BANK];
    logic [PE_W-1:0]          r_rr  [NUM_BANK];

    logic [BANK_W-1:0]        w_pe_bank [NUM_PE];
    logic [NUM_PE-1:0]        w_in_range;
    logic [NUM_PE-1:0]        w_elig;
    logic                     w_bad;
    logic [NUM_PE-1:0]        w_sel;
    logic [NUM_PE*BANK_W-1:0] w_sel_bank;
    logic [NUM_BANK-1:0]      w_load;
    logic                     w_denied;
    logic [3:0]               w_cnt_nxt [NUM_BANK];
    logic [PE_W-1:0]          w_rr_nxt  [NUM_BANK];
    logic [NUM_BANK-1:0]      w_busy_nxt;

    assign grant        = r_grant;
    assign grant_bank   = r_grant_bank;
    assign bank_busy    = r_busy;
    assign conflict_cnt = r_conflict;
    assign bank_err     = r_err;

    // Decode per-PE targets and eligibility; a PE whose grant is showing is already served.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            w_pe_bank[i]  = req_bank[i*BANK_W +: BANK_W];
            w_in_range[i] = (32'(w_pe_bank[i]) < NUM_BANK);
            w_elig[i]     = req[i] & w_in_range[i] & ~r_grant[i];
            w_bad         = w_bad | (req[i] & ~w_in_range[i]);
        end
    end

    // Per-bank round-robin selection and latency counter next state.
    always_comb begin
        int  idx;
        logic found;
        idx        = 0;
        found      = 1'b0;
        w_sel      = '0;
        w_sel_bank = '0;
        w_load     = '0;
        for (int b = 0; b < int'(NUM_BANK); b++) begin
            w_rr_nxt[b] = r_rr[b];
            found       = 1'b0;
            // cnt of 1 counts as free so the next grant lands with no bubble
            if (r_cnt[b] <= 4'd1) begin
                for (int k = 0; k < int'(NUM_PE); k++) begin
                    idx = int'(r_rr[b]) + k;
                    if (idx >= int'(NUM_PE)) begin
                        idx = idx - int'(NUM_PE);
                    end
                    if (!found && w_elig[idx] && (32'(w_pe_bank[idx]) == 32'(b))) begin
                        found                           = 1'b1;
                        w_sel[idx]                      = 1'b1;
                        w_sel_bank[idx*BANK_W +: BANK_W] = BANK_W'(b);
                        w_load[b]                       = 1'b1;
                        w_rr_nxt[b] = (idx + 1 >= int'(NUM_PE)) ? '0 : PE_W'(idx + 1);
                    end
                end
            end
            if (w_load[b]) begin
                w_cnt_nxt[b] = LAT;
            end else if (r_cnt[b] != 4'd0) begin
                w_cnt_nxt[b] = r_cnt[b] - 4'd1;
            end else begin
                w_cnt_nxt[b] = 4'd0;
            end
            w_busy_nxt[b] = (w_cnt_nxt[b] != 4'd0);
        end
        w_denied = |(w_elig & ~w_sel);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_grant_bank <= '0;
            r_busy       <= '0;
            r_conflict   <= '0;
            r_err        <= 1'b0;
            for (int b = 0; b < int'(NUM_BANK); b++) begin
                r_cnt[b] <= '0;
                r_rr[b]  <= '0;
            end
        end else begin
            r_grant      <= w_sel;
            r_grant_bank <= w_sel_bank;
            r_busy       <= w_busy_nxt;
            r_err        <= r_err | w_bad;
            for (int b = 0; b < int'(NUM_BANK); b++) begin
                r_cnt[b] <= w_cnt_nxt[b];
                r_rr[b]  <= w_rr_nxt[b];
            end
            if (conflict_clr) begin
                r_conflict <= '0;
            end else if (w_denied && (r_conflict != 16'hFFFF)) begin
                r_conflict <= r_conflict + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_edge_pe_bank_arbiter.sv
// Directed bench for edge_pe_bank_arbiter; a second instance with three banks
// exercises the out-of-range bank index.
module tb_edge_pe_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_bank;
    logic        conflict_clr;
    logic [3:0]  grant;
    logic [7:0]  grant_bank;
    logic [3:0]  bank_busy;
    logic [15:0] conflict_cnt;
    logic        bank_err;

    logic [3:0]  req3;
    logic [7:0]  req_bank3;
    logic [3:0]  grant3;
    logic [7:0]  grant_bank3;
    logic [2:0]  bank_busy3;
    logic [15:0] conflict_cnt3;
    logic        bank_err3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    edge_pe_bank_arbiter #(.NUM_PE(4), .NUM_BANK(4), .BANK_LAT(3)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_bank     (req_bank),
        .conflict_clr (conflict_clr),
        .grant        (grant),
        .grant_bank   (grant_bank),
        .bank_busy    (bank_busy),
        .conflict_cnt (conflict_cnt),
        .bank_err     (bank_err)
    );

    edge_pe_bank_arbiter #(.NUM_PE(4), .NUM_BANK(3), .BANK_LAT(3), .BANK_W(2)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .req          (req3),
        .req_bank     (req_bank3),
        .conflict_clr (1'b0),
        .grant        (grant3),
        .grant_bank   (grant_bank3),
        .bank_busy    (bank_busy3),
        .conflict_cnt (conflict_cnt3),
        .bank_err     (bank_err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_bank = '0;
        req3     = '0;
        req_bank3 = '0;
        conflict_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req = '0; req_bank = '0; req3 = '0; req_bank3 = '0; conflict_clr = 1'b0;
        #1;

        // Reset held two cycles with all PEs requesting distinct banks.
        req = 4'hF; req_bank = 8'hE4;
        step();
        chk("rst_grant_a", 32'(grant), 32'h0);
        step();
        chk("rst_grant_b", 32'(grant), 32'h0);
        chk("rst_gbank", 32'(grant_bank), 32'h0);
        chk("rst_busy", 32'(bank_busy), 32'h0);
        chk("rst_conf", 32'(conflict_cnt), 32'h0);
        chk("rst_err", 32'(bank_err), 32'h0);
        reset = 1'b0;
        chk("rst_release_grant", 32'(grant), 32'h0);
        step();
        chk("post_rst_grant", 32'(grant), 32'hF);
        req = '0;

        // Single access: PE0 -> bank 2.
        do_reset();
        req = 4'b0001; req_bank = 8'h02;
        chk("single_c0_grant", 32'(grant), 32'h0);
        step();
        chk("single_c1_grant", 32'(grant), 32'h1);
        chk("single_c1_gbank", 32'(grant_bank), 32'h2);
        chk("single_c1_busy", 32'(bank_busy), 32'h4);
        req = '0;
        step();
        chk("single_c2_busy", 32'(bank_busy), 32'h4);
        chk("single_c2_grant", 32'(grant), 32'h0);
        step();
        chk("single_c3_busy", 32'(bank_busy), 32'h4);
        step();
        chk("single_c4_busy", 32'(bank_busy), 32'h0);

        // Contention: PE1 and PE3 on bank 0.
        do_reset();
        req = 4'b1010; req_bank = 8'h00;
        step();
        chk("cont_c1_grant", 32'(grant), 32'h2);
        req = 4'b1000;
        step();
        chk("cont_c2_grant", 32'(grant), 32'h0);
        step();
        chk("cont_c3_grant", 32'(grant), 32'h0);
        step();
        chk("cont_c4_grant", 32'(grant), 32'h8);
        chk("cont_c4_gbank", 32'(grant_bank), 32'h0);
        req = '0;
        chk("cont_c4_conf", 32'(conflict_cnt), 32'd3);

        // Round robin: PE0 and PE1 continuously on bank 1.
        do_reset();
        req = 4'b0011; req_bank = 8'h05;
        for (int c = 1; c <= 10; c++) begin
            logic [3:0] exp_g;
            step();
            exp_g = 4'h0;
            if (c == 1 || c == 7) exp_g = 4'h1;
            if (c == 4 || c == 10) exp_g = 4'h2;
            chk($sformatf("rr_c%0d_grant", c), 32'(grant), 32'(exp_g));
        end
        req = '0;

        // Parallel banks: PE i -> bank i.
        do_reset();
        req = 4'hF; req_bank = 8'hE4;
        step();
        chk("par_c1_grant", 32'(grant), 32'hF);
        chk("par_c1_gbank", 32'(grant_bank), 32'hE4);
        chk("par_c1_busy", 32'(bank_busy), 32'hF);
        req = '0;
        step();
        chk("par_c2_busy", 32'(bank_busy), 32'hF);
        step();
        chk("par_c3_busy", 32'(bank_busy), 32'hF);
        chk("par_c3_conf", 32'(conflict_cnt), 32'h0);
        step();
        chk("par_c4_busy", 32'(bank_busy), 32'h0);

        // Reset during an access.
        do_reset();
        req = 4'b0001; req_bank = 8'h02;
        step();
        chk("mid_c1_grant", 32'(grant), 32'h1);
        req = '0;
        step();
        chk("mid_c2_busy", 32'(bank_busy), 32'h4);
        reset = 1'b1;
        step();
        chk("mid_c3_busy", 32'(bank_busy), 32'h0);
        reset = 1'b0;

        // Clear takes priority over a simultaneous conflict.
        do_reset();
        req = 4'b1010; req_bank = 8'h00;
        step();
        chk("clr_c1_conf", 32'(conflict_cnt), 32'd1);
        req = 4'b1000;
        conflict_clr = 1'b1;
        step();
        chk("clr_c2_conf", 32'(conflict_cnt), 32'd0);
        conflict_clr = 1'b0;
        step();
        chk("clr_c3_conf", 32'(conflict_cnt), 32'd1);
        req = '0;

        // Three-bank instance: PE2 -> bank 3 (invalid), PE0 -> bank 2 (last valid).
        do_reset();
        req3 = 4'b0101; req_bank3 = 8'h32;
        chk("oor_c0_err", 32'(bank_err3), 32'h0);
        step();
        chk("oor_c1_err", 32'(bank_err3), 32'h1);
        chk("oor_c1_grant", 32'(grant3), 32'h1);
        chk("oor_c1_gbank", 32'(grant_bank3), 32'h2);
        req3 = 4'b0100;
        step();
        chk("oor_c2_grant", 32'(grant3), 32'h0);
        req3 = '0;
        step();
        chk("oor_c3_err", 32'(bank_err3), 32'h1);
        chk("oor_c3_conf", 32'(conflict_cnt3), 32'h0);
        chk("oor_main_err", 32'(bank_err), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
